// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   Forwarding and hazard controller for the 5-stage RV32 pipeline.
//   - EX operand forwarding selects (EX/MEM has priority over MEM/WB)
//   - ID write-back bypass selects (only with WB_BYPASS_EN defined,
//     otherwise tied to 0 and the register file must be write-first)
//   - combinational load-use hazard detection (one-cycle stall + EX bubble)
//   - IDLE/MD_BUSY state machine that holds a mul/div in EX for
//     MULDIV_LAT cycles
//   - saturating count of cycles with stall_id=1
//
// Optional feature macro: WB_BYPASS_EN
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   id_valid, id_rs1, id_rs2        ID stage instruction / sources
//   ex_rs1, ex_rs2, ex_rd           ID/EX sources and destination
//   ex_regwrite, ex_memread         ID/EX control bits
//   ex_muldiv_start                 ID/EX holds a mul/div op
//   mem_rd, mem_regwrite            EX/MEM destination / write enable
//   wb_rd, wb_regwrite              MEM/WB destination / write enable
//   forward_a, forward_b            00 = regfile, 10 = EX/MEM, 01 = MEM/WB
//   id_bypass_a, id_bypass_b        ID read takes the WB write data
//   stall_if, stall_id, stall_ex    hold PC + IF/ID, hold ID/EX
//   flush_ex, flush_mem             bubble into ID/EX, EX/MEM
//   muldiv_busy                     mul/div sequence in progress
//   stall_cycles                    saturating stall_id cycle count
//   dbg_state                       mul/div FSM state (0 = IDLE, 1 = MD_BUSY)
//
// Handshake note: there is no valid/ready pair here; stall_* are
// level-sensitive holds that the pipeline registers obey in the same cycle
// they are asserted, and flush_* replace the next register contents with a
// bubble at the following clock edge.
module hazard_forward_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_regwrite,
  input  logic                  ex_memread,
  input  logic                  ex_muldiv_start,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_regwrite,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  id_bypass_a,
  output logic                  id_bypass_b,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  stall_ex,
  output logic                  flush_ex,
  output logic                  flush_mem,
  output logic                  muldiv_busy,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic                  dbg_state
);

  localparam int CNT_BITS = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(MULDIV_LAT - 2);

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  md_state_e           state_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic [CNT_W-1:0]    stall_cycles_q;
  logic [CNT_W-1:0]    stall_cycles_d;

  logic md_start;
  logic md_stall;
  logic md_busy;
  logic load_use;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;
  logic byp_a_raw;
  logic byp_b_raw;

  // A start together with ex_memread is illegal and must not launch a
  // sequence; the load-use path handles that case instead.
  assign md_start = (state_q == IDLE) && ex_muldiv_start && !ex_memread;
  assign md_stall = md_start || ((state_q == MD_BUSY) && (cnt_q != '0));
  // busy stays high through the release cycle (MD_BUSY with cnt==0)
  assign md_busy  = md_start || (state_q == MD_BUSY);

  assign load_use = ex_memread && ex_regwrite && (ex_rd != '0) && id_valid &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  always_comb begin
    fwd_a_raw = 2'b00;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs1)) begin
      fwd_a_raw = 2'b10;
    end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs1)) begin
      fwd_a_raw = 2'b01;
    end
  end

  always_comb begin
    fwd_b_raw = 2'b00;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs2)) begin
      fwd_b_raw = 2'b10;
    end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs2)) begin
      fwd_b_raw = 2'b01;
    end
  end

`ifdef WB_BYPASS_EN
  assign byp_a_raw = wb_regwrite && (wb_rd != '0) && (wb_rd == id_rs1);
  assign byp_b_raw = wb_regwrite && (wb_rd != '0) && (wb_rd == id_rs2);
`else
  assign byp_a_raw = 1'b0;
  assign byp_b_raw = 1'b0;
`endif

  // Every output is forced low while reset is held, including the purely
  // combinational forwarding paths.
  always_comb begin
    forward_a   = rst_n ? fwd_a_raw : 2'b00;
    forward_b   = rst_n ? fwd_b_raw : 2'b00;
    id_bypass_a = rst_n && byp_a_raw;
    id_bypass_b = rst_n && byp_b_raw;
    stall_if    = rst_n && (load_use || md_stall);
    stall_id    = rst_n && (load_use || md_stall);
    stall_ex    = rst_n && md_stall;
    flush_mem   = rst_n && md_stall;
    // EX holds the mul/div while it stalls, so no bubble may replace it.
    flush_ex    = rst_n && load_use && !md_stall;
    muldiv_busy = rst_n && md_busy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (md_start) begin
            state_q <= MD_BUSY;
            cnt_q   <= CNT_LOAD;
          end
        end
        MD_BUSY: begin
          // ex_muldiv_start is still high from the held op; ignore it here.
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_id && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  localparam int RW    = 5;
  localparam int LAT   = 4;
  localparam int CW    = 4;
`ifdef WB_BYPASS_EN
  localparam logic BYP_EN = 1'b1;
`else
  localparam logic BYP_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          id_valid;
  logic [RW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          ex_regwrite, ex_memread, ex_muldiv_start, mem_regwrite, wb_regwrite;
  logic [1:0]    forward_a, forward_b;
  logic          id_bypass_a, id_bypass_b;
  logic          stall_if, stall_id, stall_ex, flush_ex, flush_mem, muldiv_busy;
  logic [CW-1:0] stall_cycles;
  logic          dbg_state;

  hazard_forward_unit #(.REG_ADDR_W(RW), .MULDIV_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_muldiv_start(ex_muldiv_start), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .forward_a(forward_a), .forward_b(forward_b),
    .id_bypass_a(id_bypass_a), .id_bypass_b(id_bypass_b),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .flush_ex(flush_ex), .flush_mem(flush_mem), .muldiv_busy(muldiv_busy),
    .stall_cycles(stall_cycles), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act);
    logic [31:0] exp_v;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic expect_val(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    exp_q.push_back(exp_v);
    check(name, act);
  endtask

  // stall set: {stall_if, stall_id, stall_ex, flush_ex, flush_mem, muldiv_busy}
  task automatic expect_ctrl(input string name, input logic [5:0] exp_v);
    expect_val(name, {26'd0, stall_if, stall_id, stall_ex, flush_ex, flush_mem, muldiv_busy},
               {26'd0, exp_v});
  endtask

  // ---------------- drivers ----------------
  task automatic clear_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
    ex_regwrite = 0; ex_memread = 0; ex_muldiv_start = 0;
    mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
  endtask

  typedef struct {
    string         name;
    logic          id_valid;
    logic [RW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
    logic          ex_regwrite, ex_memread;
    logic [RW-1:0] mem_rd;
    logic          mem_regwrite;
    logic [RW-1:0] wb_rd;
    logic          wb_regwrite;
    logic [1:0]    fa, fb;
    logic          lu;
    logic          byp_a, byp_b;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string nm, input logic v, input logic [RW-1:0] irs1, irs2,
                         ers1, ers2, erd, input logic erw, emr, input logic [RW-1:0] mrd,
                         input logic mrw, input logic [RW-1:0] wrd, input logic wrw,
                         input logic [1:0] fa, fb, input logic lu, ba, bb);
    vec_t t;
    t.name = nm; t.id_valid = v; t.id_rs1 = irs1; t.id_rs2 = irs2;
    t.ex_rs1 = ers1; t.ex_rs2 = ers2; t.ex_rd = erd; t.ex_regwrite = erw;
    t.ex_memread = emr; t.mem_rd = mrd; t.mem_regwrite = mrw; t.wb_rd = wrd;
    t.wb_regwrite = wrw; t.fa = fa; t.fb = fb; t.lu = lu; t.byp_a = ba; t.byp_b = bb;
    vecs.push_back(t);
  endtask

  task automatic apply_vec(input vec_t t);
    id_valid = t.id_valid; id_rs1 = t.id_rs1; id_rs2 = t.id_rs2;
    ex_rs1 = t.ex_rs1; ex_rs2 = t.ex_rs2; ex_rd = t.ex_rd;
    ex_regwrite = t.ex_regwrite; ex_memread = t.ex_memread; ex_muldiv_start = 0;
    mem_rd = t.mem_rd; mem_regwrite = t.mem_regwrite;
    wb_rd = t.wb_rd; wb_regwrite = t.wb_regwrite;
  endtask

  initial begin
    clear_inputs();
    //       name         v  irs1 irs2 ers1 ers2 erd erw emr mrd mrw wrd wrw  fa     fb    lu ba bb
    add_vec("fwd_mem_pri", 0, 0,   0,   5,   0,   0,  0,  0,  5,  1,  5,  1, 2'b10, 2'b00, 0, 0, 0);
    add_vec("fwd_wb",      0, 0,   0,   5,   0,   0,  0,  0,  5,  0,  5,  1, 2'b01, 2'b00, 0, 0, 0);
    add_vec("fwd_rd0",     0, 0,   0,   0,   0,   0,  0,  0,  0,  1,  0,  1, 2'b00, 2'b00, 0, 0, 0);
    add_vec("fwd_rd0_nz",  0, 0,   0,   5,   5,   0,  0,  0,  0,  1,  0,  1, 2'b00, 2'b00, 0, 0, 0);
    add_vec("fwd_split",   0, 0,   0,   4,   9,   0,  0,  0,  9,  1,  4,  1, 2'b01, 2'b10, 0, 0, 0);
    add_vec("fwd_no_we",   0, 0,   0,   9,   9,   0,  0,  0,  9,  0,  9,  0, 2'b00, 2'b00, 0, 0, 0);
    add_vec("lu_rs2",      1, 1,   7,   0,   0,   7,  1,  1,  0,  0,  0,  0, 2'b00, 2'b00, 1, 0, 0);
    add_vec("lu_novalid",  0, 1,   7,   0,   0,   7,  1,  1,  0,  0,  0,  0, 2'b00, 2'b00, 0, 0, 0);
    add_vec("lu_rs1",      1, 7,   2,   0,   0,   7,  1,  1,  0,  0,  0,  0, 2'b00, 2'b00, 1, 0, 0);
    add_vec("lu_rd0",      1, 0,   0,   0,   0,   0,  1,  1,  0,  0,  0,  0, 2'b00, 2'b00, 0, 0, 0);
    add_vec("lu_no_rw",    1, 7,   7,   0,   0,   7,  0,  1,  0,  0,  0,  0, 2'b00, 2'b00, 0, 0, 0);
    add_vec("lu_no_load",  1, 7,   7,   0,   0,   7,  1,  0,  0,  0,  0,  0, 2'b00, 2'b00, 0, 0, 0);
    add_vec("byp_a",       1, 3,   4,   0,   0,   0,  0,  0,  0,  0,  3,  1, 2'b00, 2'b00, 0, BYP_EN, 0);
    add_vec("byp_b",       1, 8,   6,   0,   0,   0,  0,  0,  0,  0,  6,  1, 2'b00, 2'b00, 0, 0, BYP_EN);
    add_vec("byp_rd0",     1, 0,   0,   0,   0,   0,  0,  0,  0,  0,  0,  1, 2'b00, 2'b00, 0, 0, 0);

    // ---- reset state: matching forwarding inputs must still read 0 ----
    rst_n = 1'b0;
    ex_rs1 = 5; mem_rd = 5; mem_regwrite = 1; id_rs1 = 5; wb_rd = 5; wb_regwrite = 1;
    ex_muldiv_start = 1;
    #3;
    expect_val("rst_forward_a", {30'd0, forward_a}, 32'd0);
    expect_val("rst_bypass_a", {31'd0, id_bypass_a}, 32'd0);
    expect_ctrl("rst_ctrl", 6'b000000);
    expect_val("rst_stall_cycles", {28'd0, stall_cycles}, 32'd0);
    expect_val("rst_state", {31'd0, dbg_state}, 32'd0);
    clear_inputs();
    do_reset();

    // ---- combinational table ----
    for (int i = 0; i < vecs.size(); i++) begin
      apply_vec(vecs[i]);
      @(negedge clk);
      expect_val({vecs[i].name, "_fa"}, {30'd0, forward_a}, {30'd0, vecs[i].fa});
      expect_val({vecs[i].name, "_fb"}, {30'd0, forward_b}, {30'd0, vecs[i].fb});
      expect_ctrl({vecs[i].name, "_ctrl"},
                  {vecs[i].lu, vecs[i].lu, 1'b0, vecs[i].lu, 1'b0, 1'b0});
      expect_val({vecs[i].name, "_byp"}, {30'd0, id_bypass_a, id_bypass_b},
                 {30'd0, vecs[i].byp_a, vecs[i].byp_b});
      next_cycle();
    end
    clear_inputs();

    // ---- back-to-back mul/div: two ops of LAT cycles each ----
    do_reset();
    ex_muldiv_start = 1;
    for (int i = 0; i < 2 * LAT; i++) begin
      logic s;
      s = ((i % LAT) != LAT - 1);
      @(negedge clk);
      expect_ctrl($sformatf("md_cyc%0d", i), {s, s, s, 1'b0, s, 1'b1});
      next_cycle();
    end
    ex_muldiv_start = 0;
    @(negedge clk);
    expect_val("md_stall_cycles", {28'd0, stall_cycles}, 32'd6);
    expect_ctrl("md_after", 6'b000000);
    expect_val("md_state_idle", {31'd0, dbg_state}, 32'd0);
    next_cycle();

    // ---- illegal start with memread: load-use only, no sequence ----
    ex_muldiv_start = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 7;
    id_rs1 = 7; id_valid = 1;
    @(negedge clk);
    expect_ctrl("ill_ctrl", 6'b110100);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    expect_val("ill_state", {31'd0, dbg_state}, 32'd0);
    expect_ctrl("ill_after", 6'b000000);
    next_cycle();

    // ---- reset in the 2nd MD_BUSY cycle ----
    do_reset();
    ex_muldiv_start = 1;
    next_cycle();           // 1st MD_BUSY cycle
    next_cycle();           // 2nd MD_BUSY cycle
    expect_ctrl("rstmd_pre", 6'b111011);
    rst_n = 1'b0;
    #1;
    expect_ctrl("rstmd_ctrl", 6'b000000);
    expect_val("rstmd_cnt", {28'd0, stall_cycles}, 32'd0);
    expect_val("rstmd_state", {31'd0, dbg_state}, 32'd0);
    ex_muldiv_start = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_ctrl($sformatf("rstmd_post%0d", i), 6'b000000);
      expect_val($sformatf("rstmd_state%0d", i), {31'd0, dbg_state}, 32'd0);
      next_cycle();
    end

    // ---- saturation with CNT_W=4 (load-use held 20 cycles) ----
    do_reset();
    ex_memread = 1; ex_regwrite = 1; ex_rd = 7; id_rs2 = 7; id_valid = 1;
    for (int i = 0; i < 10; i++) next_cycle();
    expect_val("sat_10", {28'd0, stall_cycles}, 32'd10);
    for (int i = 0; i < 10; i++) next_cycle();
    expect_val("sat_20", {28'd0, stall_cycles}, 32'd15);
    for (int i = 0; i < 3; i++) next_cycle();
    expect_val("sat_hold", {28'd0, stall_cycles}, 32'd15);
    clear_inputs();
    next_cycle();
    expect_val("sat_idle", {28'd0, stall_cycles}, 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
